// File: rtl/fp32_to_fp16_if.sv
// Stream bundle for the binary32 -> binary16 converter: input operand
// channel plus result channel carrying the per-result exception flags.
interface fp32_to_fp16_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_overflow,
        output out_underflow,
        output out_inexact
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_overflow,
        input  out_underflow,
        input  out_inexact
    );
endinterface

// File: rtl/fp32_to_fp16.sv
// Two-stage IEEE-754 binary32 -> binary16 converter, round-to-nearest-even.
// Stage 1 classifies and aligns the operand; stage 2 rounds and packs.
module fp32_to_fp16 (
    input  logic             clk,
    input  logic             rst,
    fp32_to_fp16_if.slave    bus
);
    // Handshake: a word moves on a rising edge where valid && ready. A full
    // stage holds its contents (and out_* stay frozen) until it can hand off;
    // each stage advances when it is empty or the stage after it advances.
    logic        w_s1_adv;
    logic        w_s2_adv;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_mant;
    logic [3:0]  w_dshift;
    logic [34:0] w_align;
    logic [14:0] w_base;
    logic        w_guard;
    logic        w_sticky;
    logic        w_tiny;
    logic        w_ovf;
    logic        w_unf;
    logic        w_inx;

    logic        r1_valid;
    logic        r1_sign;
    logic [14:0] r1_base;
    logic        r1_guard;
    logic        r1_sticky;
    logic        r1_tiny;
    logic        r1_ovf;
    logic        r1_unf;
    logic        r1_inx;

    logic        w_round_up;
    logic [14:0] w_sum;
    logic        w_ovf2;
    logic        w_unf2;
    logic        w_inx2;

    logic        r2_valid;
    logic [15:0] r2_data;
    logic        r2_ovf;
    logic        r2_unf;
    logic        r2_inx;

    assign w_s2_adv = !r2_valid || bus.out_ready;
    assign w_s1_adv = !r1_valid || w_s2_adv;

    assign w_sign = bus.in_data[31];
    assign w_exp  = bus.in_data[30:23];
    assign w_mant = bus.in_data[22:0];

    // Subnormal results cover exp32 102..112; the fixed 14-bit part of the
    // right shift is folded into the slice below, leaving a 0..10 shift.
    assign w_dshift = 4'(8'd112 - w_exp);
    assign w_align  = {1'b1, w_mant, 11'b0} >> w_dshift;

    always_comb begin
        w_base   = 15'h0000;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_tiny   = 1'b0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_inx    = 1'b0;
        if (w_exp == 8'hFF) begin
            if (w_mant != 23'd0) begin
                w_base = {5'h1F, 1'b1, w_mant[21:13]};
            end else begin
                w_base = 15'h7C00;
            end
        end else if (w_exp == 8'h00) begin
            if (w_mant != 23'd0) begin
                w_unf = 1'b1;
                w_inx = 1'b1;
            end
        end else if (w_exp > 8'd142) begin
            w_base = 15'h7C00;
            w_ovf  = 1'b1;
            w_inx  = 1'b1;
        end else if (w_exp >= 8'd113) begin
            // Rebias by -112; modulo 32 that is exp[4:0] - 16.
            w_base   = {w_exp[4:0] - 5'd16, w_mant[22:13]};
            w_guard  = w_mant[12];
            w_sticky = |w_mant[11:0];
        end else if (w_exp >= 8'd102) begin
            w_base   = {5'd0, w_align[34:25]};
            w_guard  = w_align[24];
            w_sticky = |w_align[23:0];
            w_tiny   = 1'b1;
        end else begin
            w_unf = 1'b1;
            w_inx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_sign   <= 1'b0;
            r1_base   <= 15'h0000;
            r1_guard  <= 1'b0;
            r1_sticky <= 1'b0;
            r1_tiny   <= 1'b0;
            r1_ovf    <= 1'b0;
            r1_unf    <= 1'b0;
            r1_inx    <= 1'b0;
        end else if (w_s1_adv) begin
            r1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1_sign   <= w_sign;
                r1_base   <= w_base;
                r1_guard  <= w_guard;
                r1_sticky <= w_sticky;
                r1_tiny   <= w_tiny;
                r1_ovf    <= w_ovf;
                r1_unf    <= w_unf;
                r1_inx    <= w_inx;
            end
        end
    end

    // Adding the round bit across {exp, mant} lets a mantissa carry bump the
    // exponent: 30/0x3FF rolls to infinity, subnormal 0x3FF to min normal.
    assign w_round_up = r1_guard && (r1_sticky || r1_base[0]);
    assign w_sum      = r1_base + {14'd0, w_round_up};
    assign w_ovf2     = r1_ovf || (w_round_up && (&w_sum[14:10]));
    assign w_unf2     = r1_unf || (r1_tiny && (r1_guard || r1_sticky));
    assign w_inx2     = r1_inx || r1_guard || r1_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_data  <= 16'h0000;
            r2_ovf   <= 1'b0;
            r2_unf   <= 1'b0;
            r2_inx   <= 1'b0;
        end else if (w_s2_adv) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_data <= {r1_sign, w_sum};
                r2_ovf  <= w_ovf2;
                r2_unf  <= w_unf2;
                r2_inx  <= w_inx2;
            end
        end
    end

    assign bus.in_ready      = w_s1_adv && !rst;
    assign bus.out_valid     = r2_valid;
    assign bus.out_data      = r2_data;
    assign bus.out_overflow  = r2_ovf;
    assign bus.out_underflow = r2_unf;
    assign bus.out_inexact   = r2_inx;
endmodule

// File: doc/fp32_to_fp16.md
FP32_TO_FP16 -- requirements
Module: fp32_to_fp16

Interface
Parameters: none.
REQ-001 The module SHALL have a single clock `clk`, and a reset `rst` that is asynchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  32  IEEE-754 binary32 operand
- out_valid  output  1  out_data/flags valid
- out_ready  input  1  downstream accepts output this cycle
- out_data  output  16  IEEE-754 binary16 result
- out_overflow  output  1  finite input rounded to infinity
- out_underflow  output  1  result tiny and inexact
- out_inexact  output  1  result not exactly equal to the input

Function
REQ-003 Handshake SHALL be valid/ready: a transfer occurs on a rising edge with valid&&ready; once asserted, out_valid and the output values SHALL stay stable until the transfer.
REQ-004 The block SHALL be a 2-stage pipeline: stage 1 unpack/classify/align; stage 2 round/pack. With out_ready held high, a result SHALL appear on out_valid exactly 2 cycles after acceptance, at one result per cycle.
REQ-005 Stage advance rules SHALL be: s2_adv = !v2 || out_ready; s1_adv = !v1 || s2_adv; in_ready = s1_adv (a combinational path from out_ready is permitted).
REQ-006 Results SHALL leave the block in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-007 Notation: e = exp32 - 127; M = {1, mant32} (24 bits).
REQ-008 NaN input (exp 0xFF, mant != 0) SHALL produce {sign, 5'h1F, 1'b1, mant32[21:13]}, with no flags.
REQ-009 Infinity input SHALL produce {sign, 5'h1F, 10'h0}, with no flags.
REQ-010 Zero input SHALL produce {sign, 15'h0}, with no flags.
REQ-011 FP32 denormal input (exp 0, mant != 0) SHALL produce {sign, 15'h0}, with underflow=1 and inexact=1.
REQ-012 Normal range, -14 <= e <= 15: exp16 = e+15 and mant16 = mant32[22:13], rounded with round-to-nearest-even on the 13 dropped bits (guard = bit 12, sticky = OR of bits 11:0).
- inexact = (dropped bits != 0).
- A mantissa carry-out SHALL increment exp16.
- If exp16 reaches 31, the result SHALL be ±inf with overflow=1 and inexact=1.
REQ-013 e > 15 SHALL produce ±inf, with overflow=1 and inexact=1.
REQ-014 Denormal range, -25 <= e <= -15: M SHALL be right-shifted by (-14 - e) + 13 and then rounded RNE using guard and sticky over all shifted-out bits.
- exp16 = 0.
- A rounding carry into bit 10 SHALL yield 0x0400 (min normal), sign-extended.
- underflow = inexact.
REQ-015 e < -25 SHALL produce {sign, 15'h0}, with underflow=1 and inexact=1.
REQ-016 The sign SHALL always be passed through unchanged, including for zero and NaN results.
REQ-017 Flags SHALL be computed per result and travel with out_data; there are no sticky accumulated flags.

Reset
REQ-018 While rst=1, every pipeline valid bit, out_valid, out_data, and all flags SHALL be 0 immediately, independent of clk.
REQ-019 While rst=1, in_ready SHALL be 0. in_ready SHALL be 1 on the first cycle after deassertion.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight results; none SHALL be emitted after reset is released.

Verification
REQ-021 Basic latency: 0x3F800000 -> 0x3C00 with flags 000, and out_valid exactly 2 cycles after acceptance (out_ready=1).
REQ-022 Rounding ties:
- 0x3F801000 -> 0x3C00 (tie to even), inexact=1.
- 0x3F803000 -> 0x3C02, inexact=1.
- 0x3F800800 -> 0x3C00, inexact=1.
REQ-023 Overflow/boundary:
- 0x477FE000 (65504) -> 0x7BFF, no flags.
- 0x477FF000 (65520) -> 0x7C00, overflow=1, inexact=1.
- 0xC7800000 -> 0xFC00, overflow=1, inexact=1.
REQ-024 Underflow:
- 0x33800000 -> 0x0001, no flags.
- 0x33000000 -> 0x0000, underflow=1, inexact=1.
- 0x38800000 -> 0x0400, no flags.
- 0x387FF000 -> 0x0400, underflow=1, inexact=1.
- 0x00000001 -> 0x0000, underflow=1, inexact=1.
REQ-025 Specials: 0x7F800001 -> 0x7E00; 0xFFC00000 -> 0xFE00; 0x7F800000 -> 0x7C00; 0x80000000 -> 0x8000; all with flags 000.
REQ-026 Backpressure and reset:
- Feed 8 back-to-back inputs with out_ready toggled in the pattern 1,0,0,1,0,1,1,0,... The bench SHALL see all 8 results in order, in_ready=0 whenever both stages are full and out_ready=0, and outputs stable while stalled.
- Then assert rst with both stages valid. out_valid SHALL drop the same cycle, and no output SHALL appear after release until a new input is accepted.
